// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared types and constants for the 6502-style stack sequencer
package stack_pkg;

  typedef enum logic [2:0] {
    OP_JSR = 3'd0,
    OP_RTS = 3'd1,
    OP_BRK = 3'd2,
    OP_IRQ = 3'd3,
    OP_RTI = 3'd4
  } stack_op_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PUSH_HI,
    ST_PUSH_LO,
    ST_PUSH_P,
    ST_PULL_A,
    ST_PULL_B,
    ST_PULL_C,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  localparam logic [7:0] STACK_PAGE = 8'h01;
  localparam logic [7:0] SP_RESET   = 8'hFF;
  localparam logic [7:0] P_BIT5     = 8'h20;
  localparam logic [7:0] P_BREAK    = 8'h10;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= 3'd4;
  endfunction

endpackage

// File: rtl/stack_seq_sp_reg.sv
// rtl/stack_seq_sp_reg.sv - 8-bit stack pointer with load, increment and decrement
module sp_reg
  import stack_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [7:0] load_data_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [7:0] sp_o
);

  logic [7:0] sp_q, sp_d;

  always_comb begin
    sp_d = sp_q;
    if (load_i)     sp_d = load_data_i;
    else if (inc_i) sp_d = sp_q + 8'd1;
    else if (dec_i) sp_d = sp_q - 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) sp_q <= SP_RESET;
    else         sp_q <= sp_d;
  end

  assign sp_o = sp_q;

endmodule

// File: rtl/stack_seq.sv
// rtl/stack_seq.sv - push/pull sequencer for JSR, RTS, BRK, IRQ and RTI
module stack_seq
  import stack_pkg::*;
(
  input  logic        ph2,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] pc_in,
  input  logic [7:0]  p_in,
  input  logic        sp_we,
  input  logic [7:0]  sp_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  output logic        busy,
  output logic        done,
  output logic [15:0] pc_out,
  output logic [7:0]  p_out,
  output logic [7:0]  sp_out
);

  state_t     state_q, state_d;
  stack_op_t  op_q;
  logic [15:0] pc_q;
  logic [7:0]  p_q;
  logic [7:0]  pcl_q, praw_q;
  logic [15:0] pc_out_q;
  logic [7:0]  p_out_q;
  logic [7:0]  sp, sp_plus1, push_p;
  logic        accept, sp_load, sp_inc, sp_dec;

  assign accept   = (state_q == ST_IDLE) && start && op_legal(op);
  assign sp_plus1 = sp + 8'd1;
  assign push_p   = (op_q == OP_BRK) ? (p_q | P_BIT5 | P_BREAK)
                                     : ((p_q | P_BIT5) & ~P_BREAK);

  sp_reg u_sp_reg (
    .clk_i       (ph2),
    .reset_i     (reset),
    .load_i      (sp_load),
    .load_data_i (sp_wdata),
    .inc_i       (sp_inc),
    .dec_i       (sp_dec),
    .sp_o        (sp)
  );

  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = 8'h00;
    mem_addr  = {STACK_PAGE, sp};
    sp_load   = 1'b0;
    sp_inc    = 1'b0;
    sp_dec    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ((op == OP_RTS) || (op == OP_RTI)) ? ST_PULL_A : ST_PUSH_HI;
        end else if (sp_we) begin
          sp_load = 1'b1;
        end
      end
      ST_PUSH_HI: begin
        mem_we    = 1'b1;
        mem_wdata = pc_q[15:8];
        sp_dec    = 1'b1;
        state_d   = ST_PUSH_LO;
      end
      ST_PUSH_LO: begin
        mem_we    = 1'b1;
        mem_wdata = pc_q[7:0];
        sp_dec    = 1'b1;
        state_d   = (op_q == OP_JSR) ? ST_DONE : ST_PUSH_P;
      end
      ST_PUSH_P: begin
        mem_we    = 1'b1;
        mem_wdata = push_p;
        sp_dec    = 1'b1;
        state_d   = ST_DONE;
      end
      // Pulls pre-increment: address the byte above SP, then move SP onto it.
      ST_PULL_A: begin
        mem_re   = 1'b1;
        mem_addr = {STACK_PAGE, sp_plus1};
        sp_inc   = 1'b1;
        state_d  = ST_PULL_B;
      end
      ST_PULL_B: begin
        mem_re   = 1'b1;
        mem_addr = {STACK_PAGE, sp_plus1};
        sp_inc   = 1'b1;
        state_d  = (op_q == OP_RTI) ? ST_PULL_C : ST_CAPTURE;
      end
      ST_PULL_C: begin
        mem_re   = 1'b1;
        mem_addr = {STACK_PAGE, sp_plus1};
        sp_inc   = 1'b1;
        state_d  = ST_CAPTURE;
      end
      ST_CAPTURE: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ph2) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_JSR;
      pc_q     <= 16'h0000;
      p_q      <= 8'h00;
      pcl_q    <= 8'h00;
      praw_q   <= 8'h00;
      pc_out_q <= 16'h0000;
      p_out_q  <= P_BIT5;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= stack_op_t'(op);
        pc_q <= pc_in;
        p_q  <= p_in;
      end
      // Read data lags the strobe by a cycle, so each byte lands one state later.
      case (state_q)
        ST_PULL_B: begin
          if (op_q == OP_RTS) pcl_q <= mem_rdata;
          else                praw_q <= mem_rdata;
        end
        ST_PULL_C: pcl_q <= mem_rdata;
        ST_CAPTURE: begin
          if (op_q == OP_RTS) begin
            pc_out_q <= {mem_rdata, pcl_q} + 16'd1;
          end else begin
            pc_out_q <= {mem_rdata, pcl_q};
            p_out_q  <= {praw_q[7:6], 2'b10, praw_q[3:0]};
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign pc_out = pc_out_q;
  assign p_out  = p_out_q;
  assign sp_out = sp;

endmodule

// File: tb/tb_stack_seq.sv
// tb/tb_stack_seq.sv - scoreboard bench for stack_seq against a stack-level reference model
module tb_stack_seq;

  logic        ph2 = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [15:0] pc_in = 16'h0;
  logic [7:0]  p_in = 8'h0;
  logic        sp_we = 1'b0;
  logic [7:0]  sp_wdata = 8'h0;
  logic [7:0]  mem_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_re, busy, done;
  logic [15:0] pc_out;
  logic [7:0]  p_out, sp_out;

  stack_seq dut (
    .ph2(ph2), .reset(reset), .start(start), .op(op), .pc_in(pc_in), .p_in(p_in),
    .sp_we(sp_we), .sp_wdata(sp_wdata), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .busy(busy), .done(done),
    .pc_out(pc_out), .p_out(p_out), .sp_out(sp_out)
  );

  always #5 ph2 = ~ph2;

  int cyc = 0;
  always @(posedge ph2) cyc <= cyc + 1;

  // Stack page memory seen by the DUT; pokes preload it from the bench.
  logic [7:0] bus_mem [256];
  logic       pl_we = 1'b0;
  logic [7:0] pl_addr = 8'h0, pl_data = 8'h0;
  always @(posedge ph2) begin
    if (pl_we)       bus_mem[pl_addr] <= pl_data;
    else if (mem_we) bus_mem[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= mem_re ? bus_mem[mem_addr[7:0]] : 8'h00;
  end

  typedef struct { logic [15:0] addr; logic [7:0] data; logic we; } acc_t;
  typedef struct { logic [15:0] pc; logic [7:0] p; logic [7:0] sp; int lat; int st; } done_t;
  acc_t  exp_acc[$];
  done_t exp_done[$];

  int n_checks = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event not as required", name);
  endtask

  // Reference model: a byte array stack and an 8-bit pointer.
  logic [7:0]  m_stack [256];
  logic [7:0]  m_sp = 8'hFF;
  logic [15:0] m_pc_out = 16'h0000;
  logic [7:0]  m_p_out = 8'h20;

  task automatic m_push(input logic [7:0] b);
    exp_acc.push_back('{addr: 16'h0100 | 16'(m_sp), data: b, we: 1'b1});
    m_stack[m_sp] = b;
    m_sp = m_sp - 8'd1;
  endtask

  task automatic m_pull(output logic [7:0] b);
    m_sp = m_sp + 8'd1;
    exp_acc.push_back('{addr: 16'h0100 | 16'(m_sp), data: 8'h00, we: 1'b0});
    b = m_stack[m_sp];
  endtask

  task automatic model_op(input logic [2:0] o, input logic [15:0] pc, input logic [7:0] p,
                          input logic spwe, input logic [7:0] spw);
    logic [7:0] lo, hi, pr;
    int lat;
    lat = 0;
    case (o)
      3'd0: begin m_push(pc[15:8]); m_push(pc[7:0]); lat = 3; end
      3'd2: begin m_push(pc[15:8]); m_push(pc[7:0]); m_push(p | 8'h30); lat = 4; end
      3'd3: begin m_push(pc[15:8]); m_push(pc[7:0]); m_push((p | 8'h20) & 8'hEF); lat = 4; end
      3'd1: begin m_pull(lo); m_pull(hi); m_pc_out = {hi, lo} + 16'd1; lat = 4; end
      3'd4: begin
        m_pull(pr); m_pull(lo); m_pull(hi);
        m_pc_out = {hi, lo};
        m_p_out = (pr | 8'h20) & 8'hEF;
        lat = 5;
      end
      default: if (spwe) m_sp = spw;
    endcase
    if (lat != 0)
      exp_done.push_back('{pc: m_pc_out, p: m_p_out, sp: m_sp, lat: lat, st: cyc});
  endtask

  acc_t  ma;
  done_t md;
  always @(negedge ph2) begin
    if (mem_we || mem_re) begin
      chk("we_re_exclusive", {31'd0, mem_we & mem_re}, 32'd0);
      if (exp_acc.size() == 0) fail_now("unexpected_access");
      else begin
        ma = exp_acc.pop_front();
        chk("acc_addr", 32'(mem_addr), 32'(ma.addr));
        chk("acc_we", {31'd0, mem_we}, {31'd0, ma.we});
        if (ma.we) chk("acc_wdata", 32'(mem_wdata), 32'(ma.data));
      end
    end
    if (done) begin
      if (exp_done.size() == 0) fail_now("unexpected_done");
      else begin
        md = exp_done.pop_front();
        chk("done_pc_out", 32'(pc_out), 32'(md.pc));
        chk("done_p_out", 32'(p_out), 32'(md.p));
        chk("done_sp_out", 32'(sp_out), 32'(md.sp));
        chk("done_latency", 32'(cyc - md.st), 32'(md.lat));
      end
    end
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge ph2);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge ph2);
    pl_we = 1'b0;
    m_stack[a] = d;
  endtask

  task automatic set_sp(input logic [7:0] v);
    @(negedge ph2);
    sp_we = 1'b1; sp_wdata = v;
    @(negedge ph2);
    sp_we = 1'b0;
    m_sp = v;
    chk("sp_load", 32'(sp_out), 32'(v));
  endtask

  task automatic do_op(input logic [2:0] o, input logic [15:0] pc, input logic [7:0] p,
                       input logic spwe, input logic [7:0] spw, input logic noise);
    bit found;
    found = 1'b0;
    @(negedge ph2);
    model_op(o, pc, p, spwe, spw);
    start = 1'b1; op = o; pc_in = pc; p_in = p; sp_we = spwe; sp_wdata = spw;
    @(negedge ph2);
    start = 1'b0; sp_we = 1'b0;
    if (o > 3'd4) begin
      chk("illegal_not_busy", {31'd0, busy}, 32'd0);
    end else begin
      for (int n = 0; n < 12; n++) begin
        if (done) begin found = 1'b1; break; end
        if (noise) begin
          start = 1'($urandom_range(0, 1)); op = 3'($urandom_range(0, 7));
          sp_we = 1'($urandom_range(0, 1)); sp_wdata = 8'($urandom);
          pc_in = 16'($urandom); p_in = 8'($urandom);
        end
        @(negedge ph2);
      end
      start = 1'b0; sp_we = 1'b0;
      if (!found) fail_now("done_timeout");
    end
  endtask

  initial begin
    repeat (2) @(negedge ph2);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_re", {31'd0, mem_re}, 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'h01FF);
    chk("rst_wdata", 32'(mem_wdata), 32'h00);
    chk("rst_pc_out", 32'(pc_out), 32'h0000);
    chk("rst_p_out", 32'(p_out), 32'h20);
    chk("rst_sp_out", 32'(sp_out), 32'hFF);
    reset = 1'b0;

    for (int a = 0; a < 256; a++) poke(8'(a), 8'($urandom));

    do_op(3'd0, 16'hF005, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("jsr_sp", 32'(sp_out), 32'hFD);
    do_op(3'd1, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("rts_pc", 32'(pc_out), 32'hF006);
    chk("rts_sp", 32'(sp_out), 32'hFF);

    set_sp(8'h01);
    do_op(3'd2, 16'h1234, 8'h81, 1'b0, 8'h00, 1'b0);
    chk("brk_sp", 32'(sp_out), 32'hFE);
    chk("brk_pc_hold", 32'(pc_out), 32'hF006);

    poke(8'hFF, 8'hFF); poke(8'h00, 8'h78); poke(8'h01, 8'h56);
    do_op(3'd4, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("rti_p", 32'(p_out), 32'hEF);
    chk("rti_pc", 32'(pc_out), 32'h5678);
    chk("rti_sp", 32'(sp_out), 32'h01);

    set_sp(8'h10);
    poke(8'h11, 8'hFF); poke(8'h12, 8'hFF);
    do_op(3'd1, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("rts_wrap_pc", 32'(pc_out), 32'h0000);

    // Abort a JSR while it is in PUSH_LO.
    set_sp(8'hFF);
    @(negedge ph2);
    model_op(3'd0, 16'hABCD, 8'h00, 1'b0, 8'h00);
    void'(exp_done.pop_back());
    start = 1'b1; op = 3'd0; pc_in = 16'hABCD;
    @(negedge ph2);
    start = 1'b0;
    @(posedge ph2);
    #1 reset = 1'b1;
    @(posedge ph2);
    #1 reset = 1'b0;
    m_sp = 8'hFF; m_pc_out = 16'h0000; m_p_out = 8'h20;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_sp", 32'(sp_out), 32'hFF);
    repeat (3) @(negedge ph2);

    do_op(3'd0, 16'h4321, 8'h00, 1'b1, 8'h80, 1'b0);
    chk("start_beats_load_sp", 32'(sp_out), 32'hFD);
    do_op(3'd5, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0);
    do_op(3'd7, 16'h0000, 8'h00, 1'b1, 8'h42, 1'b0);
    chk("illegal_load_sp", 32'(sp_out), 32'h42);

    for (int i = 0; i < 200; i++)
      do_op(3'($urandom_range(0, 7)), 16'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)), 8'($urandom), 1'b1);

    repeat (4) @(negedge ph2);
    chk("acc_queue_drained", 32'(exp_acc.size()), 32'd0);
    chk("done_queue_drained", 32'(exp_done.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
